// File: rtl/regbank_param_if.sv
// regbank_param_if: decoder/ALU-side bundle for the register bank.
// Ports (master = decoder side, slave = register bank):
//   clear            start a clear sweep
//   ctrl             write enable
//   write, datareg   write address and data
//   reg1, reg2       read addresses
//   read1, read2     registered read data
//   busy             clear sweep in progress
interface regbank_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
);
    logic              clear;
    logic              ctrl;
    logic [ADDR_W-1:0] write;
    logic [DATA_W-1:0] datareg;
    logic [ADDR_W-1:0] reg1;
    logic [ADDR_W-1:0] reg2;
    logic [DATA_W-1:0] read1;
    logic [DATA_W-1:0] read2;
    logic              busy;
    modport master (
        output clear, ctrl, write, datareg, reg1, reg2,
        input  read1, read2, busy
    );
    modport slave (
        input  clear, ctrl, write, datareg, reg1, reg2,
        output read1, read2, busy
    );
endinterface

// File: rtl/regbank_param.sv
// regbank_param: 2**ADDR_W x DATA_W register file, falling-edge, with bypass, optional zero reg and clear sweep.
// Ports:
//   clk   clock, state updates on the falling edge
//   rst   asynchronous active-high reset
//   bus   regbank_param_if.slave (clear, ctrl, write, datareg, reg1, reg2 in; read1, read2, busy out)
module regbank_param #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 2,
    parameter int ZERO_REG = 0
) (
    input  logic            clk,
    input  logic            rst,
    regbank_param_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam bit ZR    = (ZERO_REG != 0);
    typedef enum logic {IDLE, SWEEP} state_t;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DATA_W-1:0] read1_q, read1_d;
    logic [DATA_W-1:0] read2_q, read2_d;
    logic              wr_ok;
    logic [DATA_W-1:0] rd1, rd2;
    // With the zero register, address 0 neither accepts writes nor bypasses.
    assign wr_ok = bus.ctrl && !(ZR && bus.write == '0);
    assign rd1 = (ZR && bus.reg1 == '0) ? '0 :
                 (bus.ctrl && bus.write == bus.reg1) ? bus.datareg : mem_q[bus.reg1];
    assign rd2 = (ZR && bus.reg2 == '0) ? '0 :
                 (bus.ctrl && bus.write == bus.reg2) ? bus.datareg : mem_q[bus.reg2];
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        mem_d   = mem_q;
        read1_d = rd1;
        read2_d = rd2;
        if (state_q == SWEEP) begin
            mem_d[ptr_q] = '0;
            ptr_d        = ptr_q + 1'b1;
            read1_d      = '0;
            read2_d      = '0;
            state_d      = (&ptr_q) ? IDLE : SWEEP;
        end else if (bus.clear) begin
            state_d = SWEEP;
            ptr_d   = '0;
            read1_d = '0;
            read2_d = '0;
        end else if (wr_ok) begin
            mem_d[bus.write] = bus.datareg;
        end
    end
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            read1_q <= '0;
            read2_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            read1_q <= read1_d;
            read2_q <= read2_d;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end
    assign bus.read1 = read1_q;
    assign bus.read2 = read2_q;
    assign bus.busy  = (state_q == SWEEP);
endmodule
